amba3_axi2apb_bridge: RTL and testbench

- Synthesizable AXI3 slave to APB3 master bridge. The downstream consumer of AXI traffic produced by the team's AXI master VIP, and the upstream feeder of APB slaves.
- Converts each AXI burst into a sequence of single-word APB transfers, with one outstanding transaction at a time.
- Maps APB errors onto AXI responses using the package response encoding.

---
 rtl/amba3_axi2apb_bridge_pkg.sv | 39 +++
 rtl/amba3_axi_burst_addr_gen.sv | 37 +++
 rtl/amba3_axi2apb_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_amba3_axi2apb_bridge.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba3_axi2apb_bridge_pkg.sv
// Shared AMBA3 types for the AXI3-to-APB3 bridge.
//   burst_type_e   : AXI burst encodings
//   resp_type_e    : AXI response encodings
//   bridge_state_e : bridge controller states
//   BEAT_BYTES     : bytes moved per beat (one 32-bit APB word)
//   burst_illegal(): true for reserved bursts and WRAP lengths that are not 2/4/8/16 beats
package amba3_axi2apb_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDAT,
    ST_SETUP,
    ST_ACCESS,
    ST_BRESP,
    ST_RDAT
  } bridge_state_e;

  localparam int unsigned BEAT_BYTES = 4;

  function automatic logic burst_illegal(input logic [3:0] len, input burst_type_e burst);
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

endpackage

// File: rtl/amba3_axi_burst_addr_gen.sv
// Combinational AXI beat address generator.
//   addr      : address of the current beat
//   len       : AXI burst length (beats - 1)
//   burst     : AXI burst type
//   next_addr : address of the following beat (4 bytes per beat, size ignored)
//   illegal   : burst cannot be executed (reserved type or bad WRAP length)
module amba3_axi_burst_addr_gen
  import amba3_axi2apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  burst_type_e           burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    // NOTE: every output gets a value on every path through the block, so no latch is inferred.
    incr_addr = addr + ADDR_WIDTH'(BEAT_BYTES);
    // For legal WRAP lengths (len+1 is a power of two) the block size minus one
    // is simply {len, 2'b11} with 4-byte beats.
    wrap_mask = ADDR_WIDTH'({len, 2'b11});
    illegal   = burst_illegal(len, burst);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/amba3_axi2apb_bridge.sv
// AXI3 slave to APB3 master bridge, one outstanding transaction at a time.
//   aclk/areset         : clock, synchronous active-high reset
//   aw*/w*/b*           : AXI write address, data and response channels
//   ar*/r*              : AXI read address and data channels
//   paddr/pwdata/psel/penable/pwrite/prdata/pready/pslverr : APB3 master port
// Each AXI beat becomes one APB transfer; illegal bursts and partial-strobe
// write beats are answered with SLVERR without touching APB.
module amba3_axi2apb_bridge
  import amba3_axi2apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  bridge_state_e         state;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_len;
  burst_type_e           cmd_burst;
  logic                  cmd_write;
  logic [3:0]            beat;
  logic                  err_acc;
  logic                  prefer_write;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cmd_illegal;
  logic                  ar_illegal;
  logic                  aw_grant;
  logic                  ar_grant;
  logic                  last_beat;
  logic                  wlast_bad;
  logic                  skip_beat;

  // Beat size is fixed at one word, so the AXI size fields carry no information here.
  logic unused_sizes;
  assign unused_sizes = ^{awsize, arsize};

  amba3_axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (cmd_addr),
    .len       (cmd_len),
    .burst     (cmd_burst),
    .next_addr (next_addr),
    .illegal   (cmd_illegal)
  );

  // Round robin: when both channels request, serve the one not served last.
  assign aw_grant = (state == ST_IDLE) && awvalid && (!arvalid || prefer_write);
  assign ar_grant = (state == ST_IDLE) && arvalid && !aw_grant;
  assign awready  = aw_grant;
  assign arready  = ar_grant;
  assign wready   = (state == ST_WDAT);

  assign ar_illegal = burst_illegal(arlen, burst_type_e'(arburst));
  assign last_beat  = (beat == cmd_len);
  assign wlast_bad  = (wlast != last_beat);
  assign skip_beat  = cmd_illegal || (wstrb != 4'hF);

  always_ff @(posedge aclk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (areset) begin
      state        <= ST_IDLE;
      cmd_id       <= '0;
      cmd_addr     <= '0;
      cmd_len      <= '0;
      cmd_burst    <= BURST_FIXED;
      cmd_write    <= 1'b0;
      beat         <= '0;
      err_acc      <= 1'b0;
      prefer_write <= 1'b1;
      bid          <= '0;
      bresp        <= RESP_OKAY;
      bvalid       <= 1'b0;
      rid          <= '0;
      rdata        <= '0;
      rresp        <= RESP_OKAY;
      rlast        <= 1'b0;
      rvalid       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_grant) begin
            cmd_id       <= awid;
            cmd_addr     <= awaddr;
            cmd_len      <= awlen;
            cmd_burst    <= burst_type_e'(awburst);
            cmd_write    <= 1'b1;
            beat         <= '0;
            err_acc      <= 1'b0;
            prefer_write <= 1'b0;
            state        <= ST_WDAT;
          end else if (ar_grant) begin
            cmd_id       <= arid;
            cmd_addr     <= araddr;
            cmd_len      <= arlen;
            cmd_burst    <= burst_type_e'(arburst);
            cmd_write    <= 1'b0;
            beat         <= '0;
            err_acc      <= 1'b0;
            prefer_write <= 1'b1;
            if (ar_illegal) begin
              // No APB traffic: answer the first beat straight away.
              rvalid <= 1'b1;
              rid    <= arid;
              rdata  <= '0;
              rresp  <= RESP_SLVERR;
              rlast  <= (arlen == 4'd0);
              state  <= ST_RDAT;
            end else begin
              psel    <= 1'b1;
              pwrite  <= 1'b0;
              paddr   <= araddr;
              state   <= ST_SETUP;
            end
          end
        end

        ST_WDAT: begin
          if (wvalid) begin
            if (skip_beat) begin
              err_acc  <= 1'b1;
              cmd_addr <= next_addr;
              if (last_beat) begin
                bvalid <= 1'b1;
                bid    <= cmd_id;
                bresp  <= RESP_SLVERR;
                state  <= ST_BRESP;
              end else begin
                beat <= beat + 4'd1;
              end
            end else begin
              err_acc <= err_acc | wlast_bad;
              psel    <= 1'b1;
              pwrite  <= 1'b1;
              paddr   <= cmd_addr;
              pwdata  <= wdata;
              state   <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            cmd_addr <= next_addr;
            if (cmd_write) begin
              if (last_beat) begin
                bvalid <= 1'b1;
                bid    <= cmd_id;
                bresp  <= (err_acc || pslverr) ? RESP_SLVERR : RESP_OKAY;
                state  <= ST_BRESP;
              end else begin
                err_acc <= err_acc | pslverr;
                beat    <= beat + 4'd1;
                state   <= ST_WDAT;
              end
            end else begin
              rvalid <= 1'b1;
              rid    <= cmd_id;
              rdata  <= prdata;
              rresp  <= pslverr ? RESP_SLVERR : RESP_OKAY;
              rlast  <= last_beat;
              state  <= ST_RDAT;
            end
          end
        end

        ST_BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_RDAT: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              beat <= beat + 4'd1;
              if (cmd_illegal) begin
                rvalid <= 1'b1;
                rdata  <= '0;
                rresp  <= RESP_SLVERR;
                rlast  <= ((beat + 4'd1) == cmd_len);
              end else begin
                psel   <= 1'b1;
                pwrite <= 1'b0;
                paddr  <= cmd_addr;
                state  <= ST_SETUP;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba3_axi2apb_bridge.sv
// Self-checking bench for amba3_axi2apb_bridge: directed cases followed by
// randomized AXI traffic, checked against a transaction-level model.
module tb_amba3_axi2apb_bridge;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int LIMIT = 600;

  logic          aclk = 1'b0;
  logic          areset;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr, paddr;
  logic [3:0]    awlen, arlen, wstrb;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [31:0]   wdata, rdata, pwdata, prdata;
  logic          psel, penable, pwrite, pready, pslverr;

  always #5 aclk = ~aclk;

  amba3_axi2apb_bridge #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          waits;
  } apb_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  apb_exp_t    exp_apb[$];
  r_exp_t      exp_r[$];
  logic [31:0] apb_log[$];
  int          total = 0;
  int          bad = 0;
  int          wcnt = 0;

  logic [31:0] w_data[16];
  logic [3:0]  w_strb[16];
  logic        w_wlast[16];
  logic        w_err[16];
  int          w_waits[16];
  logic [31:0] r_data[16];
  logic        r_err[16];
  int          r_waits[16];
  logic [1:0]  exp_bresp;
  logic [1:0]  last_bresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_illegal(input logic [3:0] len, input logic [1:0] burst);
    if (burst == 2'd3) return 1'b1;
    if (burst == 2'd2) return !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return 1'b0;
  endfunction

  // Address of beat n, stepping one word at a time from the start address.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [3:0] len,
                                             input logic [1:0] burst, input int n);
    logic [31:0] a;
    logic [31:0] blk;
    logic [31:0] base;
    a = start;
    blk = (32'(len) + 32'd1) * 32'd4;
    for (int i = 0; i < n; i++) begin
      if (burst == 2'd1) a = a + 32'd4;
      else if (burst == 2'd2) begin
        base = a - (a % blk);
        a = base + ((a - base + 32'd4) % blk);
      end
    end
    return a;
  endfunction

  task automatic default_beats(input logic [3:0] len);
    for (int i = 0; i < 16; i++) begin
      w_data[i]  = $urandom;
      w_strb[i]  = 4'hF;
      w_wlast[i] = (i == int'(len));
      w_err[i]   = 1'b0;
      w_waits[i] = 0;
      r_data[i]  = $urandom;
      r_err[i]   = 1'b0;
      r_waits[i] = 0;
    end
  endtask

  task automatic plan_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    logic ill;
    logic err;
    apb_exp_t e;
    ill = model_illegal(len, burst);
    err = ill;
    for (int i = 0; i <= int'(len); i++) begin
      if (w_wlast[i] != (i == int'(len))) err = 1'b1;
      if (ill || w_strb[i] != 4'hF) err = 1'b1;
      else begin
        e.addr = model_addr(addr, len, burst, i);
        e.wr = 1'b1; e.data = w_data[i]; e.err = w_err[i]; e.waits = w_waits[i];
        exp_apb.push_back(e);
        if (w_err[i]) err = 1'b1;
      end
    end
    exp_bresp = err ? 2'd2 : 2'd0;
  endtask

  task automatic plan_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    logic ill;
    apb_exp_t e;
    r_exp_t r;
    ill = model_illegal(len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      r.last = (i == int'(len));
      if (ill) begin
        r.data = 32'd0; r.resp = 2'd2;
      end else begin
        e.addr = model_addr(addr, len, burst, i);
        e.wr = 1'b0; e.data = r_data[i]; e.err = r_err[i]; e.waits = r_waits[i];
        exp_apb.push_back(e);
        r.data = r_data[i]; r.resp = r_err[i] ? 2'd2 : 2'd0;
      end
      exp_r.push_back(r);
    end
  endtask

  // ---------------- APB slave + per-cycle compare ----------------
  always @(negedge aclk) begin
    if (areset) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel) begin
      if (exp_apb.size() == 0) begin
        check("apb_unexpected_psel", 64'(psel), 64'd0);
        pready = 1'b0;
      end else begin
        check("paddr", 64'(paddr), 64'(exp_apb[0].addr));
        check("pwrite", 64'(pwrite), 64'(exp_apb[0].wr));
        if (exp_apb[0].wr) check("pwdata", 64'(pwdata), 64'(exp_apb[0].data));
        if (!penable) begin
          wcnt   = exp_apb[0].waits;
          pready = 1'b0;
        end else if (wcnt > 0) begin
          wcnt--;
          pready = 1'b0;
        end else begin
          pready  = 1'b1;
          prdata  = exp_apb[0].data;
          pslverr = exp_apb[0].err;
          apb_log.push_back(paddr);
          void'(exp_apb.pop_front());
        end
      end
    end else begin
      check("penable_without_psel", 64'(penable), 64'd0);
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end
  end

  // ---------------- AXI drivers ----------------
  task automatic send_aw(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < LIMIT) begin
      @(negedge aclk); #1; n++;
    end
    if (!awready) timeout_fail("aw_handshake");
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < LIMIT) begin
      @(negedge aclk); #1; n++;
    end
    if (!arready) timeout_fail("ar_handshake");
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] len);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = w_data[i]; wstrb = w_strb[i]; wlast = w_wlast[i];
      n = 0;
      #1;
      while (!wready && n < LIMIT) begin
        @(negedge aclk); #1; n++;
      end
      if (!wready) begin
        timeout_fail("w_handshake");
        wvalid = 1'b0;
        return;
      end
      @(negedge aclk);
      wvalid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge aclk);
    end
  endtask

  task automatic recv_b(input logic [IW-1:0] id);
    int n;
    n = 0;
    while (!bvalid && n < LIMIT) begin
      @(negedge aclk); n++;
    end
    if (!bvalid) begin
      timeout_fail("bvalid");
      return;
    end
    repeat ($urandom_range(0, 2)) @(negedge aclk);
    bready = 1'b1;
    check("bvalid_held", 64'(bvalid), 64'd1);
    check("bid", 64'(bid), 64'(id));
    check("bresp", 64'(bresp), 64'(exp_bresp));
    last_bresp = bresp;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic recv_r(input logic [IW-1:0] id);
    int n;
    r_exp_t r;
    while (exp_r.size() > 0) begin
      r = exp_r.pop_front();
      n = 0;
      while (!rvalid && n < LIMIT) begin
        @(negedge aclk); n++;
      end
      if (!rvalid) begin
        timeout_fail("rvalid");
        exp_r.delete();
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      rready = 1'b1;
      check("rvalid_held", 64'(rvalid), 64'd1);
      check("rid", 64'(rid), 64'(id));
      check("rdata", 64'(rdata), 64'(r.data));
      check("rresp", 64'(rresp), 64'(r.resp));
      check("rlast", 64'(rlast), 64'(r.last));
      @(negedge aclk);
      rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    plan_write(addr, len, burst);
    send_aw(id, addr, len, burst);
    send_w(len);
    recv_b(id);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    plan_read(addr, len, burst);
    send_ar(id, addr, len, burst);
    recv_r(id);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] wrap_exp[4];
  int          n_wait;

  initial begin
    wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge aclk);

    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // INCR write, zero-wait APB
    apb_log.delete();
    default_beats(4'd3);
    do_write(4'd5, 32'h100, 4'd3, 2'd1);
    check("incr_count", 64'(apb_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < apb_log.size(); i++)
      check("incr_paddr", 64'(apb_log[i]), 64'h100 + 64'(4 * i));
    check("incr_bresp", 64'(last_bresp), 64'd0);

    // WRAP read
    apb_log.delete();
    default_beats(4'd3);
    do_read(4'd9, 32'h38, 4'd3, 2'd2);
    check("wrap_count", 64'(apb_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < apb_log.size(); i++)
      check("wrap_paddr", 64'(apb_log[i]), 64'(wrap_exp[i]));

    // FIXED read with 5 wait states on beat 0
    apb_log.delete();
    default_beats(4'd1);
    r_waits[0] = 5;
    do_read(4'd2, 32'h44, 4'd1, 2'd0);
    check("fixed_count", 64'(apb_log.size()), 64'd2);
    for (int i = 0; i < 2 && i < apb_log.size(); i++)
      check("fixed_paddr", 64'(apb_log[i]), 64'h44);

    // pslverr on beat 1 of a 3-beat write
    default_beats(4'd2);
    w_err[1] = 1'b1;
    do_write(4'd1, 32'h200, 4'd2, 2'd1);
    check("pslverr_bresp", 64'(last_bresp), 64'd2);

    // partial strobe on beat 0: that beat issues no APB transfer
    apb_log.delete();
    default_beats(4'd1);
    w_strb[0] = 4'h3;
    do_write(4'd6, 32'h240, 4'd1, 2'd1);
    check("strb_count", 64'(apb_log.size()), 64'd1);
    check("strb_bresp", 64'(last_bresp), 64'd2);

    // illegal bursts: reserved type write, WRAP len=2 read
    apb_log.delete();
    default_beats(4'd3);
    do_write(4'd7, 32'h300, 4'd3, 2'd3);
    check("rsvd_bresp", 64'(last_bresp), 64'd2);
    default_beats(4'd2);
    do_read(4'd8, 32'h300, 4'd2, 2'd2);
    check("illegal_no_apb", 64'(apb_log.size()), 64'd0);

    // AW and AR together after a read: write goes first
    default_beats(4'd1);
    plan_write(32'h400, 4'd1, 2'd1);
    plan_read(32'h500, 4'd1, 2'd1);
    fork
      begin send_aw(4'd3, 32'h400, 4'd1, 2'd1); send_w(4'd1); recv_b(4'd3); end
      begin send_ar(4'd4, 32'h500, 4'd1, 2'd1); recv_r(4'd4); end
    join
    check("arb1_drained", 64'(exp_apb.size()), 64'd0);

    // after a write, both together: read goes first
    default_beats(4'd0);
    do_write(4'd2, 32'h600, 4'd0, 2'd1);
    default_beats(4'd1);
    plan_read(32'h700, 4'd1, 2'd1);
    plan_write(32'h800, 4'd1, 2'd1);
    fork
      begin send_aw(4'd10, 32'h800, 4'd1, 2'd1); send_w(4'd1); recv_b(4'd10); end
      begin send_ar(4'd11, 32'h700, 4'd1, 2'd1); recv_r(4'd11); end
    join
    check("arb2_drained", 64'(exp_apb.size()), 64'd0);

    // reset during ACCESS
    default_beats(4'd0);
    w_waits[0] = 20;
    plan_write(32'h900, 4'd0, 2'd1);
    send_aw(4'd3, 32'h900, 4'd0, 2'd1);
    send_w(4'd0);
    n_wait = 0;
    while (!(psel && penable) && n_wait < 50) begin
      @(negedge aclk); n_wait++;
    end
    if (!(psel && penable)) timeout_fail("reach_access");
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check("rst_mid_psel", 64'(psel), 64'd0);
    check("rst_mid_penable", 64'(penable), 64'd0);
    check("rst_mid_bvalid", 64'(bvalid), 64'd0);
    areset = 1'b0;
    exp_apb.delete();
    repeat (8) begin
      @(negedge aclk);
      check("rst_no_bvalid", 64'(bvalid), 64'd0);
    end

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      logic [3:0]  len;
      logic [1:0]  burst;
      logic [31:0] addr;
      logic [IW-1:0] id;
      len   = 4'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      addr  = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
      id    = IW'($urandom);
      default_beats(len);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 7) == 0) w_strb[i] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 15) == 0) w_wlast[i] = ~w_wlast[i];
        w_err[i]   = ($urandom_range(0, 7) == 0);
        r_err[i]   = ($urandom_range(0, 7) == 0);
        w_waits[i] = $urandom_range(0, 2);
        r_waits[i] = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 1) == 1) do_write(id, addr, len, burst);
      else do_read(id, addr, len, burst);
      check("rand_drained", 64'(exp_apb.size()), 64'd0);
    end

    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
